change_dispenser: RTL and testbench

Coin-out side of the vending datapath. It takes a change amount in cents, using the same 16-bit coin encoding the vending FSM accepts (10, 20, 50, 100, 200). It issues that amount as a paced sequence of individual coins to the hopper over a valid/ready handshake, tracking a per-denomination coin inventory. Any amount it cannot pay is reported as a shortfall.

---
 rtl/change_dispenser.sv | 179 +++++++++++++++++
 tb/tb_change_dispenser.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
`timescale 1ns/1ps
// change_dispenser
//   Pays out a requested change amount as a paced sequence of single coins
//   (200/100/50/20/10 cents, largest affordable first) over a valid/ready
//   handshake. It tracks a saturating per-denomination inventory and reports
//   any amount it could not pay as a shortfall.
//
// Ports
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   req_valid/ready : change request handshake; req_ready is high only in IDLE
//   req_amount      : requested change in cents
//   busy            : controller not idle
//   coin_valid/value: coin presented to the hopper (value 0 when not valid)
//   coin_ready      : hopper accepts the presented coin
//   refill*         : add refill_count coins to denomination refill_sel (0..4)
//   done            : one-cycle pulse when a request finishes
//   shortfall       : undelivered cents, held until the next accepted request
//   inv_empty       : bit i set when inventory i is zero
module change_dispenser #(
    parameter int COIN_GAP = 2,
    parameter int INV_INIT = 8,
    parameter int INV_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [15:0]      req_amount,
    output logic             req_ready,
    output logic             busy,
    output logic             coin_valid,
    output logic [15:0]      coin_value,
    input  logic             coin_ready,
    input  logic             refill,
    input  logic [2:0]       refill_sel,
    input  logic [INV_W-1:0] refill_count,
    output logic             done,
    output logic [15:0]      shortfall,
    output logic [4:0]       inv_empty
);

    localparam int GW = (COIN_GAP > 1) ? $clog2(COIN_GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PRESENT,
        S_GAP,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [15:0]      r_rem;
    logic [INV_W-1:0] r_inv [5];
    logic [2:0]       r_idx;
    logic [GW-1:0]    r_gap;

    logic             w_found;
    logic [2:0]       w_pick;
    logic             w_hs;
    logic [15:0]      w_rem_after;
    logic [INV_W:0]   w_sum     [5];
    logic [INV_W-1:0] w_inv_nxt [5];

    function automatic logic [15:0] denom(input logic [2:0] idx);
        case (idx)
            3'd0:    denom = 16'd10;
            3'd1:    denom = 16'd20;
            3'd2:    denom = 16'd50;
            3'd3:    denom = 16'd100;
            3'd4:    denom = 16'd200;
            default: denom = 16'd0;
        endcase
    endfunction

    assign req_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign w_hs        = (r_state == S_PRESENT) && coin_ready;
    assign w_rem_after = r_rem - coin_value;

    // Ascending scan: the last qualifying index is the largest coin.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (r_inv[i] != '0 && denom(3'(i)) <= r_rem) begin
                w_found = 1'b1;
                w_pick  = 3'(i);
            end
        end
    end

    // One extra bit catches overflow; refill and dispense on the same edge
    // combine to +count-1 before saturating.
    always_comb begin
        for (int unsigned i = 0; i < 5; i++) begin
            w_sum[i] = {1'b0, r_inv[i]};
            if (refill && refill_sel == 3'(i))
                w_sum[i] = w_sum[i] + {1'b0, refill_count};
            if (w_hs && r_idx == 3'(i))
                w_sum[i] = w_sum[i] - (INV_W+1)'(1);
            w_inv_nxt[i] = w_sum[i][INV_W] ? '1 : w_sum[i][INV_W-1:0];
        end
    end

    always_comb begin
        inv_empty = '0;
        for (int unsigned i = 0; i < 5; i++)
            inv_empty[i] = (r_inv[i] == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rem      <= '0;
            r_idx      <= '0;
            r_gap      <= '0;
            coin_valid <= 1'b0;
            coin_value <= '0;
            done       <= 1'b0;
            shortfall  <= '0;
            for (int unsigned i = 0; i < 5; i++)
                r_inv[i] <= INV_W'(INV_INIT);
        end else begin
            done <= 1'b0;
            for (int unsigned i = 0; i < 5; i++)
                r_inv[i] <= w_inv_nxt[i];

            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_rem     <= req_amount;
                        shortfall <= '0;
                        r_state   <= (req_amount == '0) ? S_DONE : S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (w_found) begin
                        coin_valid <= 1'b1;
                        coin_value <= denom(w_pick);
                        r_idx      <= w_pick;
                        r_state    <= S_PRESENT;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_PRESENT: begin
                    if (coin_ready) begin
                        r_rem      <= w_rem_after;
                        coin_valid <= 1'b0;
                        coin_value <= '0;
                        r_gap      <= '0;
                        if (w_rem_after == '0)
                            r_state <= S_DONE;
                        else if (COIN_GAP > 0)
                            r_state <= S_GAP;
                        else
                            r_state <= S_SELECT;
                    end
                end
                S_GAP: begin
                    if (r_gap == GW'(COIN_GAP - 1)) begin
                        r_gap   <= '0;
                        r_state <= S_SELECT;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                S_DONE: begin
                    // Whatever is left unpaid (including a sub-10 residue) is the shortfall.
                    done      <= 1'b1;
                    shortfall <= r_rem;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
`timescale 1ns/1ps
module tb_change_dispenser;

    logic clk;
    logic rst;

    // Instance A: default parameters (INV_INIT=8, COIN_GAP=2)
    logic        a_req_valid, a_req_ready, a_busy, a_coin_valid, a_coin_ready;
    logic [15:0] a_req_amount, a_coin_value, a_shortfall;
    logic        a_refill, a_done;
    logic [2:0]  a_refill_sel;
    logic [7:0]  a_refill_count;
    logic [4:0]  a_inv_empty;

    // Instance B: INV_INIT=1
    logic        b_req_valid, b_req_ready, b_busy, b_coin_valid, b_coin_ready;
    logic [15:0] b_req_amount, b_coin_value, b_shortfall;
    logic        b_refill, b_done;
    logic [2:0]  b_refill_sel;
    logic [7:0]  b_refill_count;
    logic [4:0]  b_inv_empty;

    int n_cmp = 0;
    int n_bad = 0;

    // capture results of one request
    logic [15:0] cap_val [8];
    int          cap_t   [8];
    int          cap_n, cap_hi, cap_done_n, cap_done_t;
    logic [15:0] cap_short, cap_s0_short;
    logic        cap_rdy_done, cap_s0_busy;
    logic [7:0]  cap_snap;

    change_dispenser dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_amount(a_req_amount), .req_ready(a_req_ready),
        .busy(a_busy), .coin_valid(a_coin_valid), .coin_value(a_coin_value),
        .coin_ready(a_coin_ready), .refill(a_refill), .refill_sel(a_refill_sel),
        .refill_count(a_refill_count), .done(a_done), .shortfall(a_shortfall),
        .inv_empty(a_inv_empty)
    );

    change_dispenser #(.INV_INIT(1)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_amount(b_req_amount), .req_ready(b_req_ready),
        .busy(b_busy), .coin_valid(b_coin_valid), .coin_value(b_coin_value),
        .coin_ready(b_coin_ready), .refill(b_refill), .refill_sel(b_refill_sel),
        .refill_count(b_refill_count), .done(b_done), .shortfall(b_shortfall),
        .inv_empty(b_inv_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit sel, input logic v, input logic [15:0] amt);
        if (sel) begin b_req_valid = v; b_req_amount = amt; end
        else     begin a_req_valid = v; a_req_amount = amt; end
    endtask

    task automatic set_cr(input bit sel, input logic v);
        if (sel) b_coin_ready = v; else a_coin_ready = v;
    endtask

    task automatic set_rf(input bit sel, input logic v, input logic [2:0] s, input logic [7:0] c);
        if (sel) begin b_refill = v; b_refill_sel = s; b_refill_count = c; end
        else     begin a_refill = v; a_refill_sel = s; a_refill_count = c; end
    endtask

    function automatic logic [7:0] inv(input bit sel, input int i);
        return sel ? dut_b.r_inv[i] : dut_a.r_inv[i];
    endfunction

    task automatic do_reset;
        set_req(0, 0, 0); set_req(1, 0, 0);
        set_cr(0, 0); set_cr(1, 0);
        set_rf(0, 0, 0, 0); set_rf(1, 0, 0, 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    // Issue one request and record what comes out over ncyc cycles.
    // Sample k is taken 1 time unit after the k-th edge following the accept edge.
    // coin_ready is withheld for the first `hold` cycles a coin is valid.
    // A refill of 3 coins to index 1 is driven into edge rf_at+1 (rf_at=0: none).
    task automatic run(input bit sel, input logic [15:0] amt, input int hold,
                       input int snap_at, input int rf_at, input int ncyc);
        logic pv, v, d;
        for (int i = 0; i < 8; i++) begin cap_val[i] = '0; cap_t[i] = -1; end
        cap_n = 0; cap_hi = 0; cap_done_n = 0; cap_done_t = -1;
        cap_short = 16'hxxxx; cap_rdy_done = 1'bx; cap_snap = 8'hxx;
        set_req(sel, 1, amt);
        set_cr(sel, hold == 0);
        tick;
        cap_s0_short = sel ? b_shortfall : a_shortfall;
        cap_s0_busy  = sel ? b_busy : a_busy;
        set_req(sel, 0, 0);
        pv = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            tick;
            v = sel ? b_coin_valid : a_coin_valid;
            d = sel ? b_done : a_done;
            if (v) cap_hi++;
            if (v && !pv && cap_n < 8) begin
                cap_val[cap_n] = sel ? b_coin_value : a_coin_value;
                cap_t[cap_n]   = k;
                cap_n++;
            end
            pv = v;
            if (d) begin
                cap_done_n++;
                cap_done_t   = k;
                cap_short    = sel ? b_shortfall : a_shortfall;
                cap_rdy_done = sel ? b_req_ready : a_req_ready;
            end
            if (k == snap_at) cap_snap = inv(sel, 1);
            set_cr(sel, cap_hi > hold);
            set_rf(sel, k == rf_at, 3'd1, 8'd3);
        end
        set_cr(sel, 0);
        set_rf(sel, 0, 0, 0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        n_cmp++; if (a_req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_a_req_ready got %b expected 1", a_req_ready); end
        n_cmp++; if (a_coin_valid !== 1'b0 || a_coin_value !== 16'd0) begin n_bad++; $display("FAIL reset_a_coin got %b/%0d expected 0/0", a_coin_valid, a_coin_value); end
        n_cmp++; if (a_done !== 1'b0 || a_shortfall !== 16'd0) begin n_bad++; $display("FAIL reset_a_done_short got %b/%0d expected 0/0", a_done, a_shortfall); end
        n_cmp++; if (a_inv_empty !== 5'b00000 || a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_a_empty_busy got %b/%b expected 00000/0", a_inv_empty, a_busy); end
        n_cmp++; if (inv(0, 3) !== 8'd8) begin n_bad++; $display("FAIL reset_a_inv3 got %0d expected 8", inv(0, 3)); end
        n_cmp++; if (b_req_ready !== 1'b1 || inv(1, 4) !== 8'd1) begin n_bad++; $display("FAIL reset_b got rdy %b inv4 %0d expected 1/1", b_req_ready, inv(1, 4)); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [15:0] ev [3];
        int et [3];
        ev = '{16'd50, 16'd20, 16'd10};
        et = '{1, 5, 9};
        do_reset;
        run(0, 16'd80, 0, 0, 0, 20);
        n_cmp++; if (cap_n !== 3) begin n_bad++; $display("FAIL basic_ncoins got %0d expected 3", cap_n); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (cap_val[i] !== ev[i]) begin n_bad++; $display("FAIL basic_coin%0d got %0d expected %0d", i, cap_val[i], ev[i]); end
            n_cmp++; if (cap_t[i] !== et[i]) begin n_bad++; $display("FAIL basic_time%0d got %0d expected %0d", i, cap_t[i], et[i]); end
        end
        n_cmp++; if (cap_hi !== 3) begin n_bad++; $display("FAIL basic_valid_cycles got %0d expected 3", cap_hi); end
        n_cmp++; if (cap_done_n !== 1 || cap_done_t !== 11) begin n_bad++; $display("FAIL basic_done got n=%0d t=%0d expected n=1 t=11", cap_done_n, cap_done_t); end
        n_cmp++; if (cap_short !== 16'd0) begin n_bad++; $display("FAIL basic_short got %0d expected 0", cap_short); end
        n_cmp++; if (inv(0, 0) !== 8'd7 || inv(0, 1) !== 8'd7 || inv(0, 2) !== 8'd7) begin n_bad++; $display("FAIL basic_inv got %0d/%0d/%0d expected 7/7/7", inv(0, 2), inv(0, 1), inv(0, 0)); end
        n_cmp++; if (inv(0, 3) !== 8'd8 || inv(0, 4) !== 8'd8) begin n_bad++; $display("FAIL basic_inv_untouched got %0d/%0d expected 8/8", inv(0, 4), inv(0, 3)); end
    endtask

    task automatic test_zero;
        run(0, 16'd0, 0, 0, 0, 6);
        n_cmp++; if (cap_n !== 0 || cap_hi !== 0) begin n_bad++; $display("FAIL zero_coins got %0d/%0d expected 0/0", cap_n, cap_hi); end
        n_cmp++; if (cap_s0_busy !== 1'b1) begin n_bad++; $display("FAIL zero_busy got %b expected 1", cap_s0_busy); end
        n_cmp++; if (cap_done_n !== 1 || cap_done_t !== 1) begin n_bad++; $display("FAIL zero_done got n=%0d t=%0d expected n=1 t=1", cap_done_n, cap_done_t); end
        n_cmp++; if (cap_short !== 16'd0 || cap_rdy_done !== 1'b1) begin n_bad++; $display("FAIL zero_short_rdy got %0d/%b expected 0/1", cap_short, cap_rdy_done); end
    endtask

    task automatic test_exhaust;
        logic [15:0] ev [5];
        int et [5];
        ev = '{16'd200, 16'd100, 16'd50, 16'd20, 16'd10};
        et = '{1, 5, 9, 13, 17};
        do_reset;
        run(1, 16'd390, 0, 0, 0, 30);
        n_cmp++; if (cap_n !== 5) begin n_bad++; $display("FAIL exhaust_ncoins got %0d expected 5", cap_n); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (cap_val[i] !== ev[i] || cap_t[i] !== et[i]) begin n_bad++; $display("FAIL exhaust_coin%0d got %0d@%0d expected %0d@%0d", i, cap_val[i], cap_t[i], ev[i], et[i]); end
        end
        n_cmp++; if (cap_done_n !== 1 || cap_done_t !== 22) begin n_bad++; $display("FAIL exhaust_done got n=%0d t=%0d expected n=1 t=22", cap_done_n, cap_done_t); end
        n_cmp++; if (cap_short !== 16'd10) begin n_bad++; $display("FAIL exhaust_short got %0d expected 10", cap_short); end
        n_cmp++; if (b_inv_empty !== 5'b11111) begin n_bad++; $display("FAIL exhaust_empty got %b expected 11111", b_inv_empty); end
    endtask

    task automatic test_stall;
        do_reset;
        run(0, 16'd35, 5, 6, 0, 25);
        n_cmp++; if (cap_n !== 2) begin n_bad++; $display("FAIL stall_ncoins got %0d expected 2", cap_n); end
        n_cmp++; if (cap_val[0] !== 16'd20 || cap_t[0] !== 1) begin n_bad++; $display("FAIL stall_coin0 got %0d@%0d expected 20@1", cap_val[0], cap_t[0]); end
        n_cmp++; if (cap_val[1] !== 16'd10 || cap_t[1] !== 10) begin n_bad++; $display("FAIL stall_coin1 got %0d@%0d expected 10@10", cap_val[1], cap_t[1]); end
        n_cmp++; if (cap_hi !== 7) begin n_bad++; $display("FAIL stall_valid_cycles got %0d expected 7", cap_hi); end
        n_cmp++; if (cap_snap !== 8'd8) begin n_bad++; $display("FAIL stall_inv20_held got %0d expected 8", cap_snap); end
        n_cmp++; if (inv(0, 1) !== 8'd7 || inv(0, 0) !== 8'd7) begin n_bad++; $display("FAIL stall_inv got %0d/%0d expected 7/7", inv(0, 1), inv(0, 0)); end
        n_cmp++; if (cap_done_n !== 1 || cap_done_t !== 15 || cap_short !== 16'd5) begin n_bad++; $display("FAIL stall_done got n=%0d t=%0d sf=%0d expected 1/15/5", cap_done_n, cap_done_t, cap_short); end
    endtask

    task automatic test_shortfall_hold;
        tick; tick; tick;
        n_cmp++; if (a_shortfall !== 16'd5 || a_req_ready !== 1'b1) begin n_bad++; $display("FAIL hold_short got %0d/%b expected 5/1", a_shortfall, a_req_ready); end
        run(0, 16'd10, 0, 0, 0, 10);
        n_cmp++; if (cap_s0_short !== 16'd0) begin n_bad++; $display("FAIL hold_clear got %0d expected 0", cap_s0_short); end
        n_cmp++; if (cap_n !== 1 || cap_val[0] !== 16'd10) begin n_bad++; $display("FAIL hold_coin got n=%0d v=%0d expected 1/10", cap_n, cap_val[0]); end
        n_cmp++; if (cap_done_t !== 3 || cap_short !== 16'd0 || inv(0, 0) !== 8'd6) begin n_bad++; $display("FAIL hold_done got t=%0d sf=%0d inv10=%0d expected 3/0/6", cap_done_t, cap_short, inv(0, 0)); end
    endtask

    task automatic test_refill_hs;
        do_reset;
        run(1, 16'd20, 0, 0, 1, 8);
        n_cmp++; if (cap_n !== 1 || cap_val[0] !== 16'd20) begin n_bad++; $display("FAIL refill_coin got n=%0d v=%0d expected 1/20", cap_n, cap_val[0]); end
        n_cmp++; if (inv(1, 1) !== 8'd3) begin n_bad++; $display("FAIL refill_inv20 got %0d expected 3", inv(1, 1)); end
        n_cmp++; if (cap_done_t !== 3 || cap_short !== 16'd0) begin n_bad++; $display("FAIL refill_done got t=%0d sf=%0d expected 3/0", cap_done_t, cap_short); end
        n_cmp++; if (b_inv_empty !== 5'b00000) begin n_bad++; $display("FAIL refill_empty got %b expected 00000", b_inv_empty); end
    endtask

    task automatic test_reset_mid;
        int nd, nv;
        do_reset;
        set_req(0, 1, 16'd200);
        tick;
        set_req(0, 0, 0);
        tick;
        n_cmp++; if (a_coin_valid !== 1'b1 || a_coin_value !== 16'd200) begin n_bad++; $display("FAIL mid_present got %b/%0d expected 1/200", a_coin_valid, a_coin_value); end
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_cmp++; if (a_coin_valid !== 1'b0 || a_coin_value !== 16'd0) begin n_bad++; $display("FAIL mid_abort got %b/%0d expected 0/0", a_coin_valid, a_coin_value); end
        n_cmp++; if (a_req_ready !== 1'b1 || a_busy !== 1'b0) begin n_bad++; $display("FAIL mid_idle got %b/%b expected 1/0", a_req_ready, a_busy); end
        set_cr(0, 1);
        nd = 0; nv = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (a_done) nd++;
            if (a_coin_valid) nv++;
        end
        set_cr(0, 0);
        n_cmp++; if (nd !== 0 || nv !== 0) begin n_bad++; $display("FAIL mid_quiet got done=%0d valid=%0d expected 0/0", nd, nv); end
        n_cmp++; if (inv(0, 4) !== 8'd8) begin n_bad++; $display("FAIL mid_inv200 got %0d expected 8", inv(0, 4)); end
    endtask

    initial begin
        rst = 1'b1;
        a_req_valid = 0; a_req_amount = 0; a_coin_ready = 0; a_refill = 0; a_refill_sel = 0; a_refill_count = 0;
        b_req_valid = 0; b_req_amount = 0; b_coin_ready = 0; b_refill = 0; b_refill_sel = 0; b_refill_count = 0;
        test_reset;
        test_basic;
        test_zero;
        test_exhaust;
        test_stall;
        test_shortfall_hold;
        test_refill_hs;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
